asi_rdata_buf: RTL and testbench
================================

// Module: asi_rdata_buf
// PURPOSE
//  - Read-data return stage of the AXI slave interface, between the SPRAM read port and the AXI R channel.
//  - Tags each RAM read request, then captures RAM_Q after SLV_WS wait states.
//  - Buffers beats in an ASI_RD-deep FIFO and presents them on R with VALID/READY.
//  - Drives request-side credit so the read engine never issues a read the buffer cannot hold.
// PARAMETERS
//  AXI_DW      128  R data width, bits
//  AXI_IW      8    ID tag width
//  AXI_RRESPW  2    RRESP width
//  ASI_RD      64   R buffer depth in beats; power of two, >=2
//  SLV_WS      1    RAM read latency in cycles, >=1
// PORTS
//  ACLK      in   1           clock, all logic on rising edge
//  ARESETn   in   1           async reset, active-low
//  rq_valid  in   1           RAM read issued this cycle (CEN low, WEN all high)
//  rq_ready  out  1           credit: a read request may be accepted this cycle
//  rq_id     in   AXI_IW      ID of the beat being read
//  rq_resp   in   AXI_RRESPW  response code for the beat (00 OKAY, 10 SLVERR)
//  rq_last   in   1           last beat of the burst
//  RAM_Q     in   AXI_DW      RAM read data
//  RID       out  AXI_IW      AXI R channel
//  RDATA     out  AXI_DW      AXI R channel
//  RRESP     out  AXI_RRESPW  AXI R channel
//  RLAST     out  1           AXI R channel
//  RVALID    out  1           AXI R channel
//  RREADY    in   1           AXI R channel
//  rb_idle   out  1           no beat in flight and FIFO empty
// BEHAVIOUR
//  - Reset: RVALID=0, RLAST=0, RID=0, RRESP=0, RDATA=0.
//    Reset empties the FIFO and clears the in-flight tag pipeline.
//    rq_ready=1 and rb_idle=1 while ARESETn is low and after release.
//    Reset mid-burst drops all pending beats; no partial burst is replayed.
//  - Accept: a request is accepted in cycle t when rq_valid & rq_ready.
//    rq_valid with rq_ready=0 is ignored; the read engine must hold it.
//  - Tag pipeline: SLV_WS-stage shift register of {valid, id, resp, last}, advancing every cycle.
//  - Capture: RAM_Q for the request accepted in cycle t is sampled at the edge ending cycle t+SLV_WS.
//    At that edge the beat, with its tag fields, is written to the FIFO.
//  - Latency: accept in cycle t gives RVALID=1 in cycle t+SLV_WS+1 at the earliest.
//    The FIFO output is registered; there is no bypass path.
//  - Credit: occ = FIFO occupancy, infl = valid stages in the tag pipeline.
//    Each counter is $clog2(ASI_RD+1) bits wide.
//    rq_ready = (occ + infl) < ASI_RD, decoded from registers only, with no combinational path from RREADY.
//  - FIFO: read/write pointers are $clog2(ASI_RD) bits and wrap modulo ASI_RD.
//  - Simultaneous push and pop: occ is unchanged. This is legal at full, since the pop frees the slot.
//  - Overflow: push while full with no pop cannot occur under the credit rule; checked by assertion.
//  - R handshake: RID/RDATA/RRESP/RLAST come from the FIFO head.
//    They are held stable while RVALID & !RREADY.
//    A pop occurs on RVALID & RREADY; RVALID falls only when the FIFO goes empty.
//  - Ordering: beats leave in request order; no reordering; RLAST is passed through per beat.
//  - rb_idle = (occ==0) & (infl==0); the arbiter uses it before granting a write.
// TESTING
//  - Reset: hold ARESETn=0 for 3 cycles -> RVALID=0, rq_ready=1, rb_idle=1.
//    Assert reset mid-burst with 5 beats buffered -> FIFO empty, RVALID=0 immediately.
//  - Single beat, SLV_WS=1: rq_valid=1 at t with id=0x3C, last=1, RAM_Q=0xA5..A5 at t+1
//    -> RVALID=1 at t+2, RID=0x3C, RLAST=1, RDATA=0xA5..A5, RRESP=00.
//  - Burst with backpressure: ARLEN=15 issued back-to-back, RREADY=0 throughout
//    -> 16 beats buffered, data held stable.
//    Then RREADY=1 -> 16 beats in order, RLAST only on beat 16.
//  - Credit at full, ASI_RD=4, SLV_WS=2: issue continuously with RREADY=0
//    -> exactly 4 accepted, rq_ready=0 thereafter.
//    Raise RREADY for one cycle -> rq_ready returns to 1 the next cycle; no overflow.
//  - Push and pop together at full: FIFO full and RREADY=1 while a captured beat arrives
//    -> occupancy stays at ASI_RD, no beat lost or duplicated.
//  - Error propagation: beat 2 of 4 tagged rq_resp=10 -> RRESP=10 on beat 2 only, 00 on the others.

Source files
------------

// File: rtl/asi_rdata_buf.sv
// Read-data return stage: tags SPRAM reads, captures RAM_Q after SLV_WS cycles and
// queues the beats for the AXI R channel, issuing request credit only for free slots.

module asi_rdata_buf_chk #(
    parameter int ASI_RD = 64,
    parameter int CW     = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [CW-1:0] occ_i
);
    // A beat arriving at a full buffer with no pop would be lost
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(push_i && !pop_i && (occ_i == CW'(ASI_RD))))
                else $error("asi_rdata_buf overflow");
        end
    end
endmodule

module asi_rdata_buf #(
    parameter int AXI_DW     = 128,
    parameter int AXI_IW     = 8,
    parameter int AXI_RRESPW = 2,
    parameter int ASI_RD     = 64,
    parameter int SLV_WS     = 1
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  rq_valid,
    output logic                  rq_ready,
    input  logic [AXI_IW-1:0]     rq_id,
    input  logic [AXI_RRESPW-1:0] rq_resp,
    input  logic                  rq_last,
    input  logic [AXI_DW-1:0]     RAM_Q,
    output logic [AXI_IW-1:0]     RID,
    output logic [AXI_DW-1:0]     RDATA,
    output logic [AXI_RRESPW-1:0] RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  rb_idle
);
    localparam int PW = $clog2(ASI_RD);
    localparam int CW = $clog2(ASI_RD + 1);
    localparam int TW = AXI_IW + AXI_RRESPW + 1;
    localparam int BW = TW + AXI_DW;

    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic [BW-1:0]     push_beat_s;
    logic [SLV_WS-1:0] tv_q, tv_d;
    logic [TW-1:0]     tag_q [SLV_WS];
    logic [TW-1:0]     tag_d [SLV_WS];
    logic [BW-1:0]     mem_q [ASI_RD];
    logic              mem_we_s;
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     occ_q, occ_d, infl_q, infl_d;
    logic [CW-1:0]     mem_cnt_s;
    logic              rvalid_q, rvalid_d;
    logic [BW-1:0]     out_q, out_d;
    logic              rq_ready_q, rq_ready_d;
    logic              idle_q, idle_d;

    assign accept_s    = rq_valid & rq_ready_q;
    assign push_s      = tv_q[SLV_WS-1];
    assign push_beat_s = {tag_q[SLV_WS-1], RAM_Q};
    assign pop_s       = rvalid_q & RREADY;
    // The output register always holds the head beat, so the array holds occ-RVALID beats
    assign mem_cnt_s   = occ_q - CW'(rvalid_q);

    // Tag pipeline next state: stage 0 takes the accepted request, others shift
    always_comb begin
        tv_d = '0;
        for (int i = 0; i < SLV_WS; i++) begin
            tag_d[i] = tag_q[i];
        end
        tv_d[0]  = accept_s;
        tag_d[0] = {rq_id, rq_resp, rq_last};
        for (int i = 1; i < SLV_WS; i++) begin
            tv_d[i]  = tv_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    // Tag pipeline registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            tv_q <= '0;
            for (int i = 0; i < SLV_WS; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tv_q <= tv_d;
            for (int i = 0; i < SLV_WS; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // Head refill, array write and credit/idle decode
    always_comb begin
        wr_d     = wr_q;
        rd_d     = rd_q;
        rvalid_d = rvalid_q;
        out_d    = out_q;
        mem_we_s = 1'b0;
        if (!rvalid_q || pop_s) begin
            if (mem_cnt_s != '0) begin
                out_d    = mem_q[rd_q];
                rvalid_d = 1'b1;
                rd_d     = rd_q + PW'(1);
                mem_we_s = push_s;
            end else if (push_s) begin
                out_d    = push_beat_s;
                rvalid_d = 1'b1;
            end else begin
                rvalid_d = 1'b0;
            end
        end else begin
            mem_we_s = push_s;
        end
        if (mem_we_s) begin
            wr_d = wr_q + PW'(1);
        end else begin
            wr_d = wr_q;
        end
        occ_d      = occ_q + CW'(push_s) - CW'(pop_s);
        infl_d     = infl_q + CW'(accept_s) - CW'(push_s);
        rq_ready_d = ({1'b0, occ_d} + {1'b0, infl_d}) < (CW+1)'(ASI_RD);
        idle_d     = (occ_d == '0) && (infl_d == '0);
    end

    // Beat storage; contents are don't-care until written
    always_ff @(posedge ACLK) begin
        if (mem_we_s) begin
            mem_q[wr_q] <= push_beat_s;
        end
    end

    // Pointers, counters, head register and status flags
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_q       <= '0;
            rd_q       <= '0;
            occ_q      <= '0;
            infl_q     <= '0;
            rvalid_q   <= 1'b0;
            out_q      <= '0;
            rq_ready_q <= 1'b1;
            idle_q     <= 1'b1;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            occ_q      <= occ_d;
            infl_q     <= infl_d;
            rvalid_q   <= rvalid_d;
            out_q      <= out_d;
            rq_ready_q <= rq_ready_d;
            idle_q     <= idle_d;
        end
    end

    assign RID      = out_q[BW-1 -: AXI_IW];
    assign RRESP    = out_q[AXI_DW+1 +: AXI_RRESPW];
    assign RLAST    = out_q[AXI_DW];
    assign RDATA    = out_q[AXI_DW-1:0];
    assign RVALID   = rvalid_q;
    assign rq_ready = rq_ready_q;
    assign rb_idle  = idle_q;

    asi_rdata_buf_chk #(.ASI_RD(ASI_RD), .CW(CW)) u_chk (
        .clk    (ACLK),
        .rst_n  (ARESETn),
        .push_i (push_s),
        .pop_i  (pop_s),
        .occ_i  (occ_q)
    );
endmodule

// File: tb/tb_asi_rdata_buf.sv
// Bench for asi_rdata_buf: two instances (depth 64/latency 1 and depth 4/latency 2)
// checked every cycle against an in-order transaction model of accepted/captured/popped beats.

module tb_asi_rdata_buf;
    localparam int DW = 128;
    localparam int IW = 8;
    localparam int RW = 2;
    localparam int NM = 1024;

    logic          ACLK = 1'b0;
    logic          rst_n;
    logic          rq_valid [2];
    logic          rq_ready [2];
    logic [IW-1:0] rq_id    [2];
    logic [RW-1:0] rq_resp  [2];
    logic          rq_last  [2];
    logic [DW-1:0] ram_q    [2];
    logic [IW-1:0] rid      [2];
    logic [DW-1:0] rdata    [2];
    logic [RW-1:0] rresp    [2];
    logic          rlast    [2];
    logic          rvalid   [2];
    logic          rready   [2];
    logic          rb_idle  [2];

    int total = 0;
    int bad   = 0;

    int            n_acc [2];
    int            n_cap [2];
    int            n_pop [2];
    int            cyc;
    int            m_t    [2][NM];
    logic [IW-1:0] m_id   [2][NM];
    logic [RW-1:0] m_resp [2][NM];
    logic          m_last [2][NM];
    logic [DW-1:0] m_data [2][NM];

    always #5 ACLK = ~ACLK;

    asi_rdata_buf #(.AXI_DW(DW), .AXI_IW(IW), .AXI_RRESPW(RW), .ASI_RD(64), .SLV_WS(1)) dut_a (
        .ACLK(ACLK), .ARESETn(rst_n),
        .rq_valid(rq_valid[0]), .rq_ready(rq_ready[0]), .rq_id(rq_id[0]),
        .rq_resp(rq_resp[0]), .rq_last(rq_last[0]), .RAM_Q(ram_q[0]),
        .RID(rid[0]), .RDATA(rdata[0]), .RRESP(rresp[0]), .RLAST(rlast[0]),
        .RVALID(rvalid[0]), .RREADY(rready[0]), .rb_idle(rb_idle[0])
    );

    asi_rdata_buf #(.AXI_DW(DW), .AXI_IW(IW), .AXI_RRESPW(RW), .ASI_RD(4), .SLV_WS(2)) dut_b (
        .ACLK(ACLK), .ARESETn(rst_n),
        .rq_valid(rq_valid[1]), .rq_ready(rq_ready[1]), .rq_id(rq_id[1]),
        .rq_resp(rq_resp[1]), .rq_last(rq_last[1]), .RAM_Q(ram_q[1]),
        .RID(rid[1]), .RDATA(rdata[1]), .RRESP(rresp[1]), .RLAST(rlast[1]),
        .RVALID(rvalid[1]), .RREADY(rready[1]), .rb_idle(rb_idle[1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int dep(input int d);
        return (d == 0) ? 64 : 4;
    endfunction

    // Reference model: beats are logged at acceptance, get data lat() cycles later, leave in order
    always @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0;
            for (int d = 0; d < 2; d++) begin
                n_acc[d] <= 0;
                n_cap[d] <= 0;
                n_pop[d] <= 0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int d = 0; d < 2; d++) begin
                if (n_cap[d] < n_acc[d] && m_t[d][n_cap[d] % NM] + lat(d) == cyc) begin
                    m_data[d][n_cap[d] % NM] <= ram_q[d];
                    n_cap[d] <= n_cap[d] + 1;
                end
                if (rq_valid[d] && (n_acc[d] - n_pop[d]) < dep(d)) begin
                    m_t[d][n_acc[d] % NM]    <= cyc;
                    m_id[d][n_acc[d] % NM]   <= rq_id[d];
                    m_resp[d][n_acc[d] % NM] <= rq_resp[d];
                    m_last[d][n_acc[d] % NM] <= rq_last[d];
                    n_acc[d] <= n_acc[d] + 1;
                end
                if (n_pop[d] < n_cap[d] && rready[d]) begin
                    n_pop[d] <= n_pop[d] + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input int d, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            int   k;
            logic ev;
            k  = n_pop[d] % NM;
            ev = (n_pop[d] < n_cap[d]);
            chk("rq_ready", d, DW'(rq_ready[d]), DW'((n_acc[d] - n_pop[d]) < dep(d)));
            chk("rb_idle", d, DW'(rb_idle[d]), DW'(n_acc[d] == n_pop[d]));
            chk("rvalid", d, DW'(rvalid[d]), DW'(ev));
            if (ev) begin
                chk("rid", d, DW'(rid[d]), DW'(m_id[d][k]));
                chk("rresp", d, DW'(rresp[d]), DW'(m_resp[d][k]));
                chk("rlast", d, DW'(rlast[d]), DW'(m_last[d][k]));
                chk("rdata", d, rdata[d], m_data[d][k]);
            end
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        @(negedge ACLK);
        check_all();
        for (int d = 0; d < 2; d++) begin
            ram_q[d] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic set_req(input int d, input logic v, input logic last, input logic [RW-1:0] resp);
        rq_valid[d] = v;
        rq_id[d]    = IW'($urandom);
        rq_resp[d]  = resp;
        rq_last[d]  = last;
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            set_req(d, 1'b0, 1'b0, 2'b00);
            rready[d] = 1'b0;
            ram_q[d]  = '0;
        end

        // Reset held for three cycles
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            chk("rst_rvalid", d, DW'(rvalid[d]), DW'(1'b0));
            chk("rst_ready", d, DW'(rq_ready[d]), DW'(1'b1));
            chk("rst_idle", d, DW'(rb_idle[d]), DW'(1'b1));
            chk("rst_rid", d, DW'(rid[d]), '0);
            chk("rst_rdata", d, rdata[d], '0);
            chk("rst_rresp", d, DW'(rresp[d]), '0);
            chk("rst_rlast", d, DW'(rlast[d]), '0);
        end
        rst_n = 1'b1;
        step();

        // Single beat, latency 1
        rq_valid[0] = 1'b1; rq_id[0] = 8'h3C; rq_resp[0] = 2'b00; rq_last[0] = 1'b1;
        step();
        chk("sb_early", 0, DW'(rvalid[0]), DW'(1'b0));
        set_req(0, 1'b0, 1'b0, 2'b00);
        ram_q[0] = {16{8'hA5}};
        step();
        chk("sb_rvalid", 0, DW'(rvalid[0]), DW'(1'b1));
        chk("sb_rid", 0, DW'(rid[0]), DW'(8'h3C));
        chk("sb_rlast", 0, DW'(rlast[0]), DW'(1'b1));
        chk("sb_rresp", 0, DW'(rresp[0]), DW'(2'b00));
        chk("sb_rdata", 0, rdata[0], {16{8'hA5}});
        rready[0] = 1'b1;
        step();
        rready[0] = 1'b0;

        // 16-beat burst buffered under backpressure, then drained
        for (int i = 0; i < 16; i++) begin
            set_req(0, 1'b1, (i == 15), 2'b00);
            step();
        end
        set_req(0, 1'b0, 1'b0, 2'b00);
        repeat (4) step();
        chk("burst_held", 0, DW'(rvalid[0]), DW'(1'b1));
        chk("burst_busy", 0, DW'(rb_idle[0]), DW'(1'b0));
        rready[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("burst_valid", 0, DW'(rvalid[0]), DW'(1'b1));
            chk("burst_last", 0, DW'(rlast[0]), DW'(i == 15));
            step();
        end
        chk("burst_empty", 0, DW'(rvalid[0]), DW'(1'b0));
        rready[0] = 1'b0;

        // Error response on beat 2 of 4
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b1, (i == 3), (i == 1) ? 2'b10 : 2'b00);
            step();
        end
        set_req(0, 1'b0, 1'b0, 2'b00);
        repeat (3) step();
        rready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("err_valid", 0, DW'(rvalid[0]), DW'(1'b1));
            chk("err_resp", 0, DW'(rresp[0]), DW'((i == 1) ? 2'b10 : 2'b00));
            step();
        end
        rready[0] = 1'b0;

        // Credit exhaustion at depth 4, latency 2
        cnt = 0;
        set_req(1, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 10; i++) begin
            if (rq_ready[1]) cnt++;
            step();
        end
        chk("credit_cnt", 1, DW'(cnt), DW'(4));
        chk("credit_stall", 1, DW'(rq_ready[1]), DW'(1'b0));
        rready[1] = 1'b1;
        step();
        rready[1] = 1'b0;
        chk("credit_back", 1, DW'(rq_ready[1]), DW'(1'b1));

        // Continuous issue and drain near full
        rready[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_req(1, 1'b1, ($urandom_range(3) == 0), ($urandom_range(3) == 0) ? 2'b10 : 2'b00);
            step();
        end
        set_req(1, 1'b0, 1'b0, 2'b00);
        repeat (8) step();
        chk("pp_idle", 1, DW'(rb_idle[1]), DW'(1'b1));
        rready[1] = 1'b0;

        // Reset with five beats buffered
        for (int i = 0; i < 5; i++) begin
            set_req(0, 1'b1, (i == 4), 2'b00);
            step();
        end
        set_req(0, 1'b0, 1'b0, 2'b00);
        repeat (3) step();
        chk("mr_pre", 0, DW'(rvalid[0]), DW'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("mr_rvalid", 0, DW'(rvalid[0]), DW'(1'b0));
        chk("mr_idle", 0, DW'(rb_idle[0]), DW'(1'b1));
        chk("mr_ready", 0, DW'(rq_ready[0]), DW'(1'b1));
        check_all();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("mr_after", 0, DW'(rvalid[0]), DW'(1'b0));

        // Random traffic on both instances
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < 2; d++) begin
                set_req(d, ($urandom_range(9) < 7), ($urandom_range(3) == 0),
                        ($urandom_range(3) == 0) ? 2'b10 : 2'b00);
                rready[d] = ($urandom_range(9) < 6);
            end
            step();
        end
        for (int d = 0; d < 2; d++) begin
            set_req(d, 1'b0, 1'b0, 2'b00);
            rready[d] = 1'b1;
        end
        repeat (80) step();
        for (int d = 0; d < 2; d++) begin
            chk("final_idle", d, DW'(rb_idle[d]), DW'(1'b1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
